// File: rtl/simon_round_sequencer.sv
// Simon round sequencer: builds the random colour sequence, plays it back, checks player input.
// Latency: start -> APPEND next cycle -> first LED two cycles after start; press -> echo LED next cycle.
// Backpressure: none; inputs are single-cycle pulses, presses outside WAIT_IN are ignored.
module simon_round_sequencer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned ON_SLOW = 100_000_000,
  parameter int unsigned ON_FAST = 40_000_000,
  parameter int unsigned GAP     = 20_000_000,
  parameter int unsigned TIMEOUT = 1_000_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_speed,
  input  logic [1:0]  i_difficulty,
  input  logic [15:0] i_seed,
  input  logic [3:0]  i_play_button,
  output logic [3:0]  o_led_color,
  output logic        o_busy,
  output logic [5:0]  o_score,
  output logic        o_win,
  output logic        o_lose
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [31:0] GAP_LAST  = 32'(GAP - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_PLAY_ON,
    S_PLAY_GAP,
    S_WAIT_IN,
    S_ECHO,
    S_WIN,
    S_LOSE
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [5:0]  len_q;
  logic [5:0]  idx_q;
  logic [5:0]  target_q;
  logic        speed_q;
  logic [31:0] cnt_q;
  logic [1:0]  mem_q [MAX_LEN];

  logic [15:0] lfsr_d;
  logic [5:0]  idx_d;
  logic [1:0]  cur_col;
  logic [1:0]  nxt_col;
  logic [1:0]  first_col;
  logic [31:0] on_last;
  logic [3:0]  exp_btn;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic logic [5:0] target_of(input logic [1:0] d);
    case (d)
      2'd0:    return 6'd8;
      2'd1:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Next LFSR value, neighbouring sequence entries and current phase limits.
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    idx_d     = idx_q + 6'd1;
    cur_col   = mem_q[idx_q[AW-1:0]];
    nxt_col   = mem_q[idx_d[AW-1:0]];
    // In the very first APPEND entry 0 is being written this cycle, so bypass it.
    first_col = (len_q == 6'd0) ? lfsr_d[1:0] : mem_q[0];
    on_last   = speed_q ? 32'(ON_FAST - 1) : 32'(ON_SLOW - 1);
    exp_btn   = onehot(cur_col);
  end

  // Sequence memory: one new colour per APPEND, never reset.
  always_ff @(posedge i_clk) begin
    if (state_q == S_APPEND) begin
      mem_q[len_q[AW-1:0]] <= lfsr_d[1:0];
    end
  end

  // Game FSM with registered LED / status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_INIT;
      len_q       <= '0;
      idx_q       <= '0;
      target_q    <= '0;
      speed_q     <= 1'b0;
      cnt_q       <= '0;
      o_led_color <= '0;
      o_busy      <= 1'b0;
      o_score     <= '0;
      o_win       <= 1'b0;
      o_lose      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (i_start) begin
            speed_q     <= i_speed;
            target_q    <= target_of(i_difficulty);
            lfsr_q      <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            o_score     <= '0;
            o_win       <= 1'b0;
            o_lose      <= 1'b0;
            o_busy      <= 1'b1;
            o_led_color <= '0;
            state_q     <= S_APPEND;
          end
        end

        S_APPEND: begin
          lfsr_q      <= lfsr_d;
          len_q       <= len_q + 6'd1;
          idx_q       <= '0;
          cnt_q       <= '0;
          o_led_color <= onehot(first_col);
          state_q     <= S_PLAY_ON;
        end

        S_PLAY_ON: begin
          if (cnt_q == on_last) begin
            cnt_q       <= '0;
            o_led_color <= '0;
            state_q     <= S_PLAY_GAP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        S_PLAY_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (idx_d < len_q) begin
              idx_q       <= idx_d;
              o_led_color <= onehot(nxt_col);
              state_q     <= S_PLAY_ON;
            end else begin
              idx_q   <= '0;
              state_q <= S_WAIT_IN;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        S_WAIT_IN: begin
          // A press arriving on the final timeout cycle is still evaluated.
          if (i_play_button != 4'b0000) begin
            cnt_q <= '0;
            if (i_play_button == exp_btn) begin
              o_led_color <= i_play_button;
              state_q     <= S_ECHO;
            end else begin
              o_busy  <= 1'b0;
              o_lose  <= 1'b1;
              state_q <= S_LOSE;
            end
          end else if (cnt_q == TO_LAST) begin
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_lose  <= 1'b1;
            state_q <= S_LOSE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        S_ECHO: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q       <= '0;
            o_led_color <= '0;
            if (idx_d < len_q) begin
              idx_q   <= idx_d;
              state_q <= S_WAIT_IN;
            end else begin
              idx_q   <= '0;
              o_score <= len_q;
              if (len_q == target_q) begin
                o_led_color <= 4'b1111;
                o_win       <= 1'b1;
                o_busy      <= 1'b0;
                state_q     <= S_WIN;
              end else begin
                state_q <= S_APPEND;
              end
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Directed game scenarios with random seeds/speeds against a sequence-level model of the game.
module tb_simon_round_sequencer;

  localparam int ON_S = 4;
  localparam int ON_F = 2;
  localparam int GAPC = 2;
  localparam int TOUT = 20;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_speed = 1'b0;
  logic [1:0]  i_difficulty = 2'd0;
  logic [15:0] i_seed = 16'h0001;
  logic [3:0]  i_play_button = 4'b0000;
  logic [3:0]  o_led_color;
  logic        o_busy;
  logic [5:0]  o_score;
  logic        o_win;
  logic        o_lose;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  logic [1:0] col [32];
  int         target;
  int         on_cyc;

  simon_round_sequencer #(
    .MAX_LEN(32), .ON_SLOW(ON_S), .ON_FAST(ON_F), .GAP(GAPC), .TIMEOUT(TOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_speed(i_speed),
    .i_difficulty(i_difficulty), .i_seed(i_seed), .i_play_button(i_play_button),
    .o_led_color(o_led_color), .o_busy(o_busy), .o_score(o_score),
    .o_win(o_win), .o_lose(o_lose)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a start pulse and rebuild the expected colour sequence for this game.
  task automatic start_game(input logic [15:0] seed, input logic spd, input logic [1:0] diff);
    logic [15:0] l;
    i_seed = seed; i_speed = spd; i_difficulty = diff; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int i = 0; i < 32; i++) begin
      l = lfsr_next(l);
      col[i] = l[1:0];
    end
    target = (diff == 2'd0) ? 8 : (diff == 2'd1) ? 16 : 32;
    on_cyc = spd ? ON_F : ON_S;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_led", 32'(o_led_color), 32'd0);
    chk("start_score", 32'(o_score), 32'd0);
    chk("start_win", 32'(o_win), 32'd0);
    chk("start_lose", 32'(o_lose), 32'd0);
  endtask

  // From APPEND: check every on/gap cycle of an r-step playback; optional stray start at cycle sa.
  task automatic playback(input int r, input int sa);
    int k;
    k = 0;
    tick();
    for (int i = 0; i < r; i++) begin
      for (int c = 0; c < on_cyc; c++) begin
        chk("play_on", 32'(o_led_color), 32'(oh(col[i])));
        if (k == sa) begin i_start = 1'b1; i_speed = ~i_speed; i_seed = ~i_seed; end
        tick();
        i_start = 1'b0;
        k++;
      end
      for (int c = 0; c < GAPC; c++) begin
        chk("play_gap", 32'(o_led_color), 32'd0);
        chk("play_busy", 32'(o_busy), 32'd1);
        tick();
        k++;
      end
    end
    chk("wait_led", 32'(o_led_color), 32'd0);
    chk("wait_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic press_ok(input int i, input int dly);
    int d;
    d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    for (int c = 0; c < d; c++) begin
      tick();
      chk("idle_wait_led", 32'(o_led_color), 32'd0);
      chk("idle_wait_lose", 32'(o_lose), 32'd0);
    end
    i_play_button = oh(col[i]);
    tick();
    i_play_button = 4'b0000;
    for (int c = 0; c < GAPC; c++) begin
      chk("echo_led", 32'(o_led_color), 32'(oh(col[i])));
      chk("echo_lose", 32'(o_lose), 32'd0);
      tick();
    end
  endtask

  // kind 1: wrong colour, 2: multi-bit press, 3: timeout.
  task automatic lose_step(input int i, input int r, input int kind);
    logic [1:0] wrong;
    if (kind == 3) begin
      for (int c = 0; c < TOUT - 1; c++) begin
        tick();
        chk("to_not_yet", 32'(o_lose), 32'd0);
      end
      tick();
    end else begin
      wrong = col[i] + 2'd1;
      i_play_button = (kind == 1) ? oh(wrong) : 4'b0011;
      tick();
      i_play_button = 4'b0000;
    end
    chk("lose_flag", 32'(o_lose), 32'd1);
    chk("lose_win", 32'(o_win), 32'd0);
    chk("lose_busy", 32'(o_busy), 32'd0);
    chk("lose_led", 32'(o_led_color), 32'd0);
    chk("lose_score", 32'(o_score), 32'(r - 1));
    i_play_button = 4'b0100;
    tick();
    i_play_button = 4'b0000;
    tick();
    chk("lose_hold", 32'(o_lose), 32'd1);
  endtask

  // Play a game; round fr / step fs gets fault kind fk (4 = correct press on final timeout cycle).
  task automatic run_game(input logic [15:0] seed, input logic spd, input logic [1:0] diff,
                          input int fr, input int fs, input int fk, input int sa);
    bit done;
    done = 1'b0;
    start_game(seed, spd, diff);
    for (int r = 1; r <= target && !done; r++) begin
      playback(r, (r == 1) ? sa : -1);
      for (int i = 0; i < r && !done; i++) begin
        if (r == fr && i == fs && fk != 4) begin
          lose_step(i, r, fk);
          done = 1'b1;
        end else begin
          press_ok(i, (r == fr && i == fs) ? TOUT - 1 : -1);
        end
      end
      if (!done) begin
        chk("round_score", 32'(o_score), 32'(r));
        if (r == target) begin
          chk("win_flag", 32'(o_win), 32'd1);
          chk("win_led", 32'(o_led_color), 32'hF);
          chk("win_busy", 32'(o_busy), 32'd0);
          chk("win_lose", 32'(o_lose), 32'd0);
        end else begin
          chk("append_busy", 32'(o_busy), 32'd1);
          chk("append_led", 32'(o_led_color), 32'd0);
        end
      end
    end
  endtask

  initial begin
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_led", 32'(o_led_color), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_score", 32'(o_score), 32'd0);
    chk("rst_win", 32'(o_win), 32'd0);
    chk("rst_lose", 32'(o_lose), 32'd0);
    tick();

    // Seed 1, slow, 8 rounds to WIN (first colour is Green).
    run_game(16'h0001, 1'b0, 2'd0, -1, -1, 0, -1);
    // Fast speed, stray start during playback, wrong colour on round 3 step 2.
    run_game(16'($urandom), 1'b1, 2'd0, 3, 1, 1, 1);
    // Correct press on the last allowed timeout cycle.
    run_game(16'($urandom), 1'($urandom), 2'd0, 1, 0, 4, -1);
    // Timeout in round 2.
    run_game(16'($urandom), 1'($urandom), 2'd0, 2, 1, 3, -1);
    // Multi-bit press.
    run_game(16'($urandom), 1'($urandom), 2'd0, 1, 0, 2, -1);

    // Reset in PLAY_ON clears all outputs next cycle.
    start_game(16'($urandom), 1'b0, 2'd1);
    tick();
    chk("pre_rst_led", 32'(o_led_color), 32'(oh(col[0])));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_led", 32'(o_led_color), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_score", 32'(o_score), 32'd0);
    chk("midrst_win", 32'(o_win), 32'd0);
    chk("midrst_lose", 32'(o_lose), 32'd0);

    // Seed 0 behaves as 16'hACE1; 16-step game.
    run_game(16'h0000, 1'b0, 2'd1, -1, -1, 0, -1);
    // Full 32-step game.
    run_game(16'($urandom), 1'($urandom), 2'd2, -1, -1, 0, -1);
    // Difficulty 3 (also 32 long), lose late.
    run_game(16'($urandom), 1'($urandom), 2'd3, 20, 13, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/simon_round_sequencer.md
# simon_round_sequencer

Round sequencer for the Simon (Genius) game controller: it generates and stores the random colour sequence, plays it back on the colour LEDs with speed-dependent timing, and checks the player's button presses against it step by step. It sits between the debounced play buttons / configuration switches and the LED and score outputs driven by the top-level game FSM. It reports win/lose and the completed-round score to that FSM.

## Interface
Parameters:
- MAX_LEN, 32, sequence memory depth (entries of 2 bits)
- ON_SLOW, 100_000_000, LED on-phase cycles at slow speed (0.5 s at 200 MHz)
- ON_FAST, 40_000_000, LED on-phase cycles at fast speed
- GAP, 20_000_000, LED off-phase cycles between steps; also echo duration
- TIMEOUT, 1_000_000_000, max cycles waiting for one player press

Ports (clock and reset first):
- i_clk  in  1  system clock, posedge
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_start  in  1  single-cycle start pulse
- i_speed  in  1  0: slow (ON_SLOW), 1: fast (ON_FAST)
- i_difficulty  in  2  target length: 0→8, 1→16, 2 and 3→32
- i_seed  in  16  LFSR seed
- i_play_button  in  4  debounced single-cycle press pulses [0:Green, 1:Yellow, 2:Red, 3:Blue]
- o_led_color  out  4  one-hot colour LED drive
- o_busy  out  1  high in every state except IDLE/WIN/LOSE
- o_score  out  6  completed rounds
- o_win  out  1  level, high in WIN
- o_lose  out  1  level, high in LOSE

## Operation
- States: IDLE, APPEND, PLAY_ON, PLAY_GAP, WAIT_IN, ECHO, WIN, LOSE.
- IDLE/WIN/LOSE + i_start: latch i_speed, i_difficulty (target), load LFSR with i_seed (0 replaced by 16'hACE1), len=0, score=0, clear o_win/o_lose → APPEND.
- i_start in any other state ignored.
- APPEND (1 cycle): advance LFSR once, write colour = lfsr[1:0] to mem[len], len++, idx=0 → PLAY_ON.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (shift right, XOR 16'hB400 when lsb=1).
- PLAY_ON: o_led_color = onehot(mem[idx]) for ON cycles → PLAY_GAP.
- PLAY_GAP: LED 0 for GAP cycles; then idx++, and if new idx<len → PLAY_ON, else idx=0, timeout counter cleared → WAIT_IN.
- WAIT_IN: LED 0. Any nonzero i_play_button:
  - Equal to onehot(mem[idx]) → ECHO.
  - Otherwise, including multi-bit presses → LOSE.
- WAIT_IN timeout: TIMEOUT cycles with no press → LOSE.
- ECHO: LED = pressed colour for GAP cycles; presses ignored. Then idx++, and:
  - idx<len → WAIT_IN, timeout counter cleared.
  - idx==len and len==target → score=len → WIN.
  - idx==len and len<target → score=len → APPEND.
- WIN: LED 4'b1111, o_win=1. LOSE: LED 0, o_lose=1. Both hold until i_start.
- score never exceeds target (≤32, fits 6 bits); len ≤ MAX_LEN guaranteed since target ≤ MAX_LEN.

## Timing
- Reset values: state IDLE, o_led_color 0, o_busy 0, o_score 0, o_win 0, o_lose 0, len 0, idx 0, counters 0, LFSR 16'hACE1.
- i_rst mid-game: abort next edge to reset values; sequence memory contents don't care.
- i_start sampled at edge N → APPEND during cycle N+1 → first LED on at N+2.
- Per step: exactly ON cycles on, then GAP cycles off.
- Last playback gap → WAIT_IN next cycle.
- Press sampled at edge M → ECHO LED from cycle M+1, exactly GAP cycles.
- Press in the same cycle the timeout expires: the press wins and is evaluated.
- Round-complete ECHO end → APPEND next cycle; o_score updates on that same edge.
- Outputs are registered, with no combinational path from i_play_button to outputs.

## Test plan
- Params ON_SLOW=4, ON_FAST=2, GAP=2, TIMEOUT=20, seed 16'h0001, difficulty 0. Start → first colour from lfsr after one step (16'hB400 → lfsr[1:0]=0 → Green). Required: LED 4'b0001 for 4 cycles, then 0 for 2 cycles, then WAIT_IN.
- Echo every shown step correctly for 8 rounds → o_score counts 1..8, then o_win=1, LED 4'b1111, o_busy=0.
- Round 3, wrong colour on step 2 → o_lose=1 next cycle, o_score=2, LED 0.
- No press for 20 cycles in WAIT_IN → LOSE. Press on cycle 20 → accepted (ECHO).
- Multi-bit press 4'b0011, or i_start mid-playback → LOSE for the press, ignored for the start. i_rst during PLAY_ON → all outputs 0 next cycle.
- i_speed=1 → on-phase 2 cycles. Seed 0 → identical colour sequence to seed 16'hACE1.
